// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes and the 2-bit response type,
// used by the write responder and the interconnect routers.
package axi_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  // Map a local decode error onto the AXI response code.
  function automatic axi_resp_t axi_resp_from_err(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) between the interconnect and a slave port.
interface axil_write_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi_pkg::*;

  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wvalid;
  logic                    s_wready;
  axi_resp_t               s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_awready, s_wready, s_bresp, s_bvalid
  );

endinterface

// File: rtl/axil_hold_reg.sv
// Single-entry valid/ready capture register. Ready is the registered
// inverse of the full flag, so there is no combinational valid->ready path.
module axil_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             accept,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  assign in_ready = !full;
  assign accept   = in_valid && !full;

  // Occupancy flag: set on a handshake, cleared when the write consumes it.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // Payload storage, loaded only on a handshake.
  // NOTE: the payload has no reset; it is only ever observed while full is
  // set, so resetting it would add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/axil_write_slave.sv
// AXI4-Lite write responder: buffers AW and W independently, issues a
// one-cycle local write once both halves are present, then holds a single
// B response until the interconnect accepts it.
module axil_write_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axil_write_slave_if.slave       axil,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int W_WIDTH    = DATA_WIDTH + STRB_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 aw_full;
  logic                 aw_accept;
  logic                 w_full;
  logic                 w_accept;
  logic                 buf_clear;
  logic [W_WIDTH-1:0]   w_buf;
  axi_resp_t            bresp_q;

  axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (axil.s_awvalid),
    .in_ready (axil.s_awready),
    .in_data  (axil.s_awaddr),
    .accept   (aw_accept),
    .clear    (buf_clear),
    .full     (aw_full),
    .data     (wr_addr)
  );

  axil_hold_reg #(.WIDTH(W_WIDTH)) u_w_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (axil.s_wvalid),
    .in_ready (axil.s_wready),
    .in_data  ({axil.s_wstrb, axil.s_wdata}),
    .accept   (w_accept),
    .clear    (buf_clear),
    .full     (w_full),
    .data     (w_buf)
  );

  assign wr_data = w_buf[DATA_WIDTH-1:0];
  assign wr_strb = w_buf[W_WIDTH-1:DATA_WIDTH];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and write strobe. IDLE looks at this cycle's captures as well
  // as the flags so the write follows the second handshake by one cycle.
  // No response is pending in IDLE, so the B-busy condition is implicit.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((aw_full || aw_accept) && (w_full || w_accept)) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        buf_clear  = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (axil.s_bready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response code, captured from the local error in the write cycle and
  // held until the B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bresp_q <= AXI_RESP_OKAY;
    end else if (state == ST_WRITE) begin
      bresp_q <= axi_resp_from_err(wr_err);
    end
  end

  assign axil.s_bvalid = (state == ST_RESP);
  assign axil.s_bresp  = bresp_q;

endmodule

// File: tb/tb_axil_write_slave.sv
// Self-checking bench for axil_write_slave: directed scenarios plus a random
// phase, all observed by a transaction scoreboard that pairs the k-th AW
// with the k-th W and expects one in-order response per local write.
module tb_axil_write_slave;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_err;

  always #5 clk = ~clk;

  axil_write_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_write_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .axil    (bus.slave),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard state
  logic [AW-1:0]    aw_q[$];
  logic [DW+SW-1:0] w_q[$];
  axi_resp_t        resp_q[$];
  int               wr_cyc_q[$];
  int               cycle     = 0;
  int               wr_count  = 0;
  int               b_count   = 0;
  int               ok_count  = 0;
  logic             prev_bvalid = 1'b0;
  logic             prev_bready = 1'b0;
  axi_resp_t        prev_bresp  = 2'b00;
  logic [AW-1:0]    exp_a;
  logic [DW+SW-1:0] exp_w;
  axi_resp_t        exp_r;

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      aw_q.delete();
      w_q.delete();
      resp_q.delete();
      prev_bvalid = 1'b0;
      prev_bready = 1'b0;
    end else begin
      if (prev_bvalid && !prev_bready) begin
        n_cmp++;
        if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== prev_bresp) begin
          n_bad++;
          $display("FAIL b_hold: bvalid=%b bresp=%b, required bvalid=1 bresp=%b",
                   bus.s_bvalid, bus.s_bresp, prev_bresp);
        end
      end
      if (wr_en === 1'b1) begin
        wr_count++;
        wr_cyc_q.push_back(cycle);
        n_cmp++;
        if (aw_q.size() == 0 || w_q.size() == 0 || bus.s_bvalid !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_unexpected: wr_en with aw_q=%0d w_q=%0d bvalid=%b, required both queued and bvalid=0",
                   aw_q.size(), w_q.size(), bus.s_bvalid);
        end else begin
          exp_a = aw_q.pop_front();
          exp_w = w_q.pop_front();
          if (wr_addr !== exp_a || {wr_strb, wr_data} !== exp_w) begin
            n_bad++;
            $display("FAIL wr_payload: addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                     wr_addr, wr_strb, wr_data, exp_a, exp_w[DW+SW-1:DW], exp_w[DW-1:0]);
          end
          resp_q.push_back(wr_err ? 2'b10 : 2'b00);
        end
      end
      if (bus.s_bvalid === 1'b1 && bus.s_bready === 1'b1) begin
        b_count++;
        n_cmp++;
        if (resp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected: bresp=%b with no write outstanding, required no B", bus.s_bresp);
        end else begin
          exp_r = resp_q.pop_front();
          if (bus.s_bresp !== exp_r) begin
            n_bad++;
            $display("FAIL b_resp: bresp=%b, required %b", bus.s_bresp, exp_r);
          end else if (exp_r == 2'b00) begin
            ok_count++;
          end
        end
      end
      if (bus.s_awvalid && bus.s_awready) aw_q.push_back(bus.s_awaddr);
      if (bus.s_wvalid && bus.s_wready)   w_q.push_back({bus.s_wstrb, bus.s_wdata});
      prev_bvalid = bus.s_bvalid;
      prev_bready = bus.s_bready;
      prev_bresp  = bus.s_bresp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
  endtask

  task automatic drive_pair(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.s_awaddr  = a;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = d;
    bus.s_wstrb   = s;
    bus.s_wvalid  = 1'b1;
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    bus.s_awaddr  = a;
    bus.s_awvalid = 1'b1;
    for (int i = 0; i < 64 && bus.s_awready !== 1'b1; i++) tick();
    n_cmp++;
    if (bus.s_awready !== 1'b1) begin
      n_bad++;
      $display("FAIL aw_timeout: awready=%b, required 1 within 64 cycles", bus.s_awready);
    end
    tick();
    bus.s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.s_wdata  = d;
    bus.s_wstrb  = s;
    bus.s_wvalid = 1'b1;
    for (int i = 0; i < 64 && bus.s_wready !== 1'b1; i++) tick();
    n_cmp++;
    if (bus.s_wready !== 1'b1) begin
      n_bad++;
      $display("FAIL w_timeout: wready=%b, required 1 within 64 cycles", bus.s_wready);
    end
    tick();
    bus.s_wvalid = 1'b0;
  endtask

  task automatic wait_wr(input string name, input logic [AW-1:0] a);
    int i;
    for (i = 0; i < 8 && wr_en !== 1'b1; i++) tick();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== a) begin
      n_bad++;
      $display("FAIL %s: wr_en=%b addr=%h, required wr_en=1 addr=%h within 8 cycles",
               name, wr_en, wr_addr, a);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.s_bready = 1'b1;
    wr_err       = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en} !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_hold: awready,wready,bvalid,bresp,wr_en=%b, required 110000",
               {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en});
    end
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en} !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_release: awready,wready,bvalid,bresp,wr_en=%b, required 110000",
               {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en});
    end
  endtask

  task automatic test_same_cycle();
    bus.s_bready = 1'b1;
    wr_err       = 1'b0;
    drive_pair(32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    idle_inputs();
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, wr_strb, bus.s_bvalid} !== {1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
      n_bad++;
      $display("FAIL same_wr: wr_en=%b addr=%h data=%h strb=%h bvalid=%b, required 1 00000010 deadbeef f 0",
               wr_en, wr_addr, wr_data, wr_strb, bus.s_bvalid);
    end
    tick();
    n_cmp++;
    if ({wr_en, bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready} !== 6'b010011) begin
      n_bad++;
      $display("FAIL same_b: wr_en,bvalid,bresp,awready,wready=%b, required 010011",
               {wr_en, bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready});
    end
    tick();
    n_cmp++;
    if (bus.s_bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL same_b_done: bvalid=%b, required 0", bus.s_bvalid);
    end
  endtask

  task automatic test_split();
    int b0;
    b0 = b_count;
    bus.s_bready = 1'b1;
    wr_err       = 1'b0;
    bus.s_wdata  = 32'h1234;
    bus.s_wstrb  = 4'h3;
    bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if ({bus.s_wready, bus.s_awready, wr_en} !== 3'b010) begin
        n_bad++;
        $display("FAIL split_wait%0d: wready,awready,wr_en=%b, required 010",
                 i, {bus.s_wready, bus.s_awready, wr_en});
      end
      if (i < 5) tick();
    end
    bus.s_awaddr  = 32'h20;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, wr_strb} !== {1'b1, 32'h20, 32'h1234, 4'h3}) begin
      n_bad++;
      $display("FAIL split_wr: wr_en=%b addr=%h data=%h strb=%h, required 1 00000020 00001234 3",
               wr_en, wr_addr, wr_data, wr_strb);
    end
    repeat (4) tick();
    n_cmp++;
    if (b_count - b0 !== 1) begin
      n_bad++;
      $display("FAIL split_bcount: %0d responses, required 1", b_count - b0);
    end
  endtask

  task automatic test_decode_error();
    bus.s_bready = 1'b1;
    wr_err       = 1'b1;
    drive_pair($urandom, $urandom, 4'(($urandom)));
    tick();
    idle_inputs();
    n_cmp++;
    if (wr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL err_wr: wr_en=%b, required 1", wr_en);
    end
    tick();
    wr_err = 1'b0;
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready} !== 6'b110011) begin
      n_bad++;
      $display("FAIL err_b: bvalid,bresp,wr_en,awready,wready=%b, required 110011",
               {bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic          r1;
    logic          r2;
    logic [1:0]    exp1;
    logic [AW-1:0] a2;
    r1   = 1'($urandom);
    r2   = 1'($urandom);
    exp1 = r1 ? 2'b10 : 2'b00;
    a2   = $urandom;
    bus.s_bready = 1'b0;
    wr_err       = r1;
    drive_pair($urandom, $urandom, 4'(($urandom)));
    tick();
    idle_inputs();
    tick();
    wr_err = r2;
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready} !== {1'b1, exp1, 2'b11}) begin
      n_bad++;
      $display("FAIL bp_first_b: bvalid,bresp,awready,wready=%b, required %b",
               {bus.s_bvalid, bus.s_bresp, bus.s_awready, bus.s_wready}, {1'b1, exp1, 2'b11});
    end
    drive_pair(a2, $urandom, 4'(($urandom)));
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready} !== {1'b1, exp1, 3'b000}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: bvalid,bresp,wr_en,awready,wready=%b, required %b",
                 i, {bus.s_bvalid, bus.s_bresp, wr_en, bus.s_awready, bus.s_wready},
                 {1'b1, exp1, 3'b000});
      end
      tick();
    end
    bus.s_bready = 1'b1;
    tick();
    wait_wr("bp_second_wr", a2);
    repeat (3) tick();
    wr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    bus.s_bready = 1'b0;
    wr_err       = 1'b1;
    drive_pair($urandom, $urandom, 4'(($urandom)));
    tick();
    idle_inputs();
    tick();
    wr_err = 1'b0;
    bus.s_awaddr  = $urandom;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp, bus.s_awready} !== 4'b1100) begin
      n_bad++;
      $display("FAIL rm_before: bvalid,bresp,awready=%b, required 1100",
               {bus.s_bvalid, bus.s_bresp, bus.s_awready});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en} !== 6'b110000) begin
      n_bad++;
      $display("FAIL rm_async: awready,wready,bvalid,bresp,wr_en=%b, required 110000",
               {bus.s_awready, bus.s_wready, bus.s_bvalid, bus.s_bresp, wr_en});
    end
    #10 rst = 1'b0;
    tick();
    bus.s_bready = 1'b1;
    bus.s_wdata  = $urandom;
    bus.s_wstrb  = 4'hA;
    bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({wr_en, bus.s_bvalid} !== 2'b00) begin
        n_bad++;
        $display("FAIL rm_after%0d: wr_en,bvalid=%b, required 00", i, {wr_en, bus.s_bvalid});
      end
      tick();
    end
    a = $urandom;
    send_aw(a);
    wait_wr("rm_drain_wr", a);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int   aw_left;
    int   w_left;
    int   w0;
    int   b0;
    int   ok0;
    logic aw_hs;
    logic w_hs;
    bus.s_bready = 1'b1;
    wr_err       = 1'b0;
    wr_cyc_q.delete();
    w0  = wr_count;
    b0  = b_count;
    ok0 = ok_count;
    aw_left = 8;
    w_left  = 8;
    drive_pair($urandom, $urandom, 4'(($urandom)));
    for (int g = 0; g < 200 && (aw_left > 0 || w_left > 0); g++) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      tick();
      if (aw_hs) begin
        aw_left--;
        if (aw_left > 0) bus.s_awaddr = $urandom;
        else             bus.s_awvalid = 1'b0;
      end
      if (w_hs) begin
        w_left--;
        if (w_left > 0) begin
          bus.s_wdata = $urandom;
          bus.s_wstrb = 4'(($urandom));
        end else begin
          bus.s_wvalid = 1'b0;
        end
      end
    end
    for (int i = 0; i < 30 && (b_count - b0) < 8; i++) tick();
    n_cmp++;
    if (wr_count - w0 !== 8 || ok_count - ok0 !== 8) begin
      n_bad++;
      $display("FAIL b2b_count: %0d writes %0d OKAY, required 8 and 8", wr_count - w0, ok_count - ok0);
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      n_cmp++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 3) begin
        n_bad++;
        $display("FAIL b2b_spacing%0d: %0d cycles, required 3", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
  endtask

  task automatic test_random();
    int   aw_sent;
    int   w_sent;
    logic aw_hs;
    logic w_hs;
    aw_sent = 0;
    w_sent  = 0;
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      tick();
      if (aw_hs) begin aw_sent++; bus.s_awvalid = 1'b0; end
      if (w_hs)  begin w_sent++;  bus.s_wvalid  = 1'b0; end
      if (!bus.s_awvalid && $urandom_range(0, 2) == 0) begin
        bus.s_awvalid = 1'b1;
        bus.s_awaddr  = $urandom;
      end
      if (!bus.s_wvalid && $urandom_range(0, 2) == 0) begin
        bus.s_wvalid = 1'b1;
        bus.s_wdata  = $urandom;
        bus.s_wstrb  = 4'(($urandom));
      end
      bus.s_bready = ($urandom_range(0, 3) != 0);
      wr_err       = ($urandom_range(0, 3) == 0);
    end
    bus.s_bready = 1'b1;
    for (int g = 0; g < 64 && (bus.s_awvalid || bus.s_wvalid); g++) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      tick();
      if (aw_hs) begin aw_sent++; bus.s_awvalid = 1'b0; end
      if (w_hs)  begin w_sent++;  bus.s_wvalid  = 1'b0; end
    end
    while (aw_sent < w_sent) begin send_aw($urandom); aw_sent++; end
    while (w_sent < aw_sent) begin send_w($urandom, 4'(($urandom))); w_sent++; end
    for (int i = 0; i < 20 && (aw_q.size() != 0 || w_q.size() != 0 || resp_q.size() != 0 || bus.s_bvalid); i++)
      tick();
    n_cmp++;
    if (aw_q.size() != 0 || w_q.size() != 0 || resp_q.size() != 0 || bus.s_bvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rand_drain: aw_q=%0d w_q=%0d resp_q=%0d bvalid=%b, required all empty",
               aw_q.size(), w_q.size(), resp_q.size(), bus.s_bvalid);
    end
    wr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_same_cycle();
    test_split();
    test_decode_error();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
